// File: rtl/dab_phase_shift_pwm.sv
// dab_phase_shift_pwm: phase-shifted gate generator for one primary and N_SEC secondary full bridges with dead time.
// Define DAB_PWM_SOFTSTART_EN to ramp each secondary phase from 0 by one count per period after start.
module dab_phase_shift_pwm #(
  parameter int CNT_W = 16,
  parameter int DT_W  = 8,
  parameter int N_SEC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       period_i,
  input  logic [DT_W-1:0]        dead_i,
  input  logic [N_SEC*CNT_W-1:0] phase_i,
  output logic [3:0]             Sp,
  output logic [4*N_SEC-1:0]     Ss,
  output logic                   trigger,
  output logic                   running
);
  localparam int NG = 4*N_SEC + 4;
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, STOP = 2'd3;
  localparam logic [CNT_W-1:0] ONE = 1, MIN_PER = 4;
  localparam logic [DT_W-1:0] D1 = 1;
  logic [1:0] state, state_nx;
  logic sync_q, sync_rise, active, active_nx, wrap, start, load, en;
  logic [CNT_W-1:0] cnt, per, per_c, half, dt_max, dead_x;
  logic [DT_W-1:0] dt, dt_c;
  logic [CNT_W-1:0] ph [N_SEC];
  logic [CNT_W-1:0] ph_c [N_SEC];
  logic [CNT_W-1:0] ph_eff [N_SEC];
  logic [NG-1:0] raw, gate;
  logic [DT_W-1:0] dcnt [NG];
  assign sync_rise = sync & ~sync_q;
  assign active    = state[1];
  assign active_nx = state_nx[1];
  assign wrap      = active && (cnt == per - ONE);
  assign start     = (state == ARMED) && enable && sync_rise;
  assign load      = start || wrap || ((state == RUN) && sync_rise);
  assign en        = active && active_nx;
  assign half      = per >> 1;
  assign per_c     = (period_i < MIN_PER) ? MIN_PER : period_i;
  assign dt_max    = (per_c >> 1) - ONE;
  assign dead_x    = CNT_W'(dead_i);
  assign dt_c      = (dead_x > dt_max) ? DT_W'(dt_max) : dead_i;
  assign trigger   = (state == RUN) && (cnt == '0);
  assign running   = active;
  assign Sp        = gate[3:0];
  assign Ss        = gate[NG-1:4];
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = enable ? ARMED : IDLE;
      ARMED:   state_nx = !enable ? IDLE : (sync_rise ? RUN : ARMED);
      RUN:     state_nx = enable ? RUN : STOP;
      default: state_nx = wrap ? IDLE : STOP;
    endcase
  end
  always_comb begin
    for (int k = 0; k < N_SEC; k++)
      ph_c[k] = (phase_i[k*CNT_W +: CNT_W] > per_c - ONE) ? per_c - ONE : phase_i[k*CNT_W +: CNT_W];
  end
  // Secondary position wraps with a single conditional subtract; shadow phases are always below per.
  always_comb begin
    logic [CNT_W:0] s, l;
    s = '0;
    l = '0;
    raw = '0;
    raw[3:0] = {cnt < half, cnt >= half, cnt >= half, cnt < half};
    for (int k = 0; k < N_SEC; k++) begin
      s = {1'b0, cnt} + {1'b0, ph_eff[k]};
      l = (s >= {1'b0, per}) ? s - {1'b0, per} : s;
      raw[4*k+4 +: 4] = {l < {1'b0, half}, l >= {1'b0, half}, l >= {1'b0, half}, l < {1'b0, half}};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sync_q <= 1'b0;
      cnt    <= '0;
      per    <= '0;
      dt     <= '0;
      for (int k = 0; k < N_SEC; k++) ph[k] <= '0;
    end else begin
      state  <= state_nx;
      sync_q <= sync;
      cnt    <= (!active_nx || load) ? '0 : cnt + ONE;
      if (load) begin
        per <= per_c;
        dt  <= dt_c;
        for (int k = 0; k < N_SEC; k++) ph[k] <= ph_c[k];
      end
    end
  end
`ifdef DAB_PWM_SOFTSTART_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SEC; k++) ph_eff[k] <= '0;
    end else begin
      for (int k = 0; k < N_SEC; k++)
        if (!active_nx || start) ph_eff[k] <= '0;
        else if (load)
          ph_eff[k] <= (ph_eff[k] < ph_c[k]) ? ph_eff[k] + ONE :
                       (ph_eff[k] > ph_c[k]) ? ((ph_eff[k] - ONE > per_c - ONE) ? per_c - ONE : ph_eff[k] - ONE) :
                       ph_eff[k];
    end
  end
`else
  assign ph_eff = ph;
`endif
  // Rising edges wait dt cycles in a per-gate counter; falling edges pass straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate <= '0;
      for (int i = 0; i < NG; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NG; i++)
        if (!(en && raw[i])) begin
          gate[i] <= 1'b0;
          dcnt[i] <= '0;
        end else if (dcnt[i] >= dt) gate[i] <= 1'b1;
        else dcnt[i] <= dcnt[i] + D1;
    end
  end
endmodule
